// File: rtl/prewrapper_seq.sv
// Sequencer for the prewrapper control unit: issues opcodes, tracks the controller state field,
// gates scan snapshots to the host and traps hung handshakes with a per-state watchdog.
module prewrapper_seq #(
  parameter int unsigned TIMEOUT = 4096,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             mode,
  input  logic [CNT_W-1:0] tick_count,
  input  logic [31:0]      ctrl_state,
  output logic [31:0]      ctrl_opcode,
  output logic             snap_valid,
  input  logic             snap_ack,
  output logic [CNT_W-1:0] snap_idx,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [3:0]       err_state
);

  localparam int unsigned WdW = $clog2(TIMEOUT + 1);
  localparam logic [WdW-1:0] WdLast = WdW'(TIMEOUT - 1);

  localparam logic [31:0] OpNone  = 32'd0;
  localparam logic [31:0] OpInput = 32'd1;
  localparam logic [31:0] OpRun   = 32'd2;
  localparam logic [31:0] OpEndr  = 32'd3;
  localparam logic [31:0] OpTest  = 32'd4;
  localparam logic [31:0] OpNext  = 32'd5;
  localparam logic [31:0] OpEndt  = 32'd6;

  localparam logic [3:0] CsIdle      = 4'd0;
  localparam logic [3:0] CsInputRdy  = 4'd3;
  localparam logic [3:0] CsOutputVal = 4'd5;
  localparam logic [3:0] CsScanRd    = 4'd9;

  typedef enum logic [3:0] {
    StIdle   = 4'd0,
    StInput  = 4'd1,
    StRun    = 4'd2,
    StEndr   = 4'd3,
    StTest   = 4'd4,
    StSnap   = 4'd5,
    StNext   = 4'd6,
    StWaitRd = 4'd7,
    StEndt   = 4'd8,
    StDone   = 4'd9,
    StErr    = 4'd10
  } state_e;

  state_e           state_q, state_d;
  logic             mode_q, mode_d;
  logic [CNT_W-1:0] tc_q, tc_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic [WdW-1:0]   wd_q, wd_d;
  logic [31:0]      op_q, op_d;
  logic             sv_q, sv_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [3:0]       err_state_q, err_state_d;

  logic [3:0] cs;
  logic       accept;
  logic       timed;

  assign cs = ctrl_state[3:0];

  logic unused_ctrl_state;
  assign unused_ctrl_state = ^ctrl_state[31:4];

  function automatic logic [31:0] op_of(state_e s);
    case (s)
      StInput: op_of = OpInput;
      StRun:   op_of = OpRun;
      StEndr:  op_of = OpEndr;
      StTest:  op_of = OpTest;
      StNext:  op_of = OpNext;
      StEndt:  op_of = OpEndt;
      default: op_of = OpNone;
    endcase
  endfunction

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    tc_d        = tc_q;
    idx_d       = idx_q;
    wd_d        = wd_q;
    err_d       = err_q;
    err_state_d = err_state_q;
    accept      = 1'b0;

    case (state_q)
      StIdle, StDone, StErr: begin
        if (start) begin
          state_d = StInput;
          accept  = 1'b1;
        end else if (state_q == StDone) begin
          state_d = StIdle;
        end
      end
      StInput:  if (cs == CsInputRdy) state_d = mode_q ? StTest : StRun;
      StRun:    if (cs == CsOutputVal) state_d = StEndr;
      StEndr:   if (cs == CsIdle) state_d = StDone;
      StTest:   if (cs == CsScanRd) state_d = StSnap;
      StSnap:   if (snap_ack) state_d = (idx_q == tc_q) ? StEndt : StNext;
      StNext: begin
        // Hold NEXT until the controller has left SCAN_RD so a step is never counted twice.
        if (cs != CsScanRd) begin
          state_d = StWaitRd;
          idx_d   = idx_q + 1'b1;
        end
      end
      StWaitRd: if (cs == CsScanRd) state_d = StSnap;
      StEndt:   if (cs == CsIdle) state_d = StDone;
      default:  state_d = StIdle;
    endcase

    if (accept) begin
      mode_d = mode;
      tc_d   = tick_count;
      idx_d  = '0;
      err_d  = 1'b0;
    end

    // S_SNAP waits on the host, so it is deliberately excluded from the watchdog.
    timed = !(state_q inside {StIdle, StDone, StErr, StSnap});
    if (state_d != state_q || !timed) begin
      wd_d = '0;
    end else if (wd_q == WdLast) begin
      wd_d        = '0;
      state_d     = StErr;
      err_d       = 1'b1;
      err_state_d = state_q;
    end else begin
      wd_d = wd_q + 1'b1;
    end

    op_d   = op_of(state_d);
    sv_d   = (state_d == StSnap);
    busy_d = !(state_d inside {StIdle, StDone, StErr});
    done_d = (state_d == StDone);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= StIdle;
      mode_q      <= 1'b0;
      tc_q        <= '0;
      idx_q       <= '0;
      wd_q        <= '0;
      op_q        <= OpNone;
      sv_q        <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      err_state_q <= 4'd0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      tc_q        <= tc_d;
      idx_q       <= idx_d;
      wd_q        <= wd_d;
      op_q        <= op_d;
      sv_q        <= sv_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      err_state_q <= err_state_d;
    end
  end

  assign ctrl_opcode = op_q;
  assign snap_valid  = sv_q;
  assign snap_idx    = idx_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign err         = err_q;
  assign err_state   = err_state_q;

endmodule

// File: tb/tb_prewrapper_seq.sv
// Directed bench for prewrapper_seq: a cycle vector table plus scripted multi-cycle scenarios.
module tb_prewrapper_seq;

  localparam int unsigned CntW    = 16;
  localparam int unsigned Timeout = 4096;

  logic            clk = 1'b0;
  logic            reset;
  logic            start;
  logic            mode;
  logic [CntW-1:0] tick_count;
  logic [31:0]     ctrl_state;
  logic [31:0]     ctrl_opcode;
  logic            snap_valid;
  logic            snap_ack;
  logic [CntW-1:0] snap_idx;
  logic            busy;
  logic            done;
  logic            err;
  logic [3:0]      err_state;

  int n_cmp = 0;
  int n_bad = 0;

  // Reactive controller/host model state and monitor counters.
  bit              model_en = 1'b0;
  int              ack_delay = 0;
  int              ack_wait = 0;
  int              cnt5, cnt6, cnt_done;
  logic [CntW-1:0] snaps[$];
  logic [31:0]     prev_op;
  logic            prev_sv;

  always #5 clk = ~clk;

  prewrapper_seq #(
    .TIMEOUT(Timeout),
    .CNT_W  (CntW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .mode       (mode),
    .tick_count (tick_count),
    .ctrl_state (ctrl_state),
    .ctrl_opcode(ctrl_opcode),
    .snap_valid (snap_valid),
    .snap_ack   (snap_ack),
    .snap_idx   (snap_idx),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .err_state  (err_state)
  );

  typedef struct {
    logic            start;
    logic            mode;
    logic [CntW-1:0] tc;
    logic [3:0]      cs;
    logic            ack;
    logic [31:0]     op;
    logic            busy;
    logic            done;
    logic            sv;
    logic [CntW-1:0] idx;
  } vec_t;

  vec_t vecs[15];

  function automatic vec_t mkv(logic st, logic [3:0] cs, logic ack, logic [31:0] op,
                               logic bz, logic dn, logic sv, logic [CntW-1:0] idx);
    vec_t v;
    v.start = st;
    v.mode  = 1'b1;
    v.tc    = 16'd1;
    v.cs    = cs;
    v.ack   = ack;
    v.op    = op;
    v.busy  = bz;
    v.done  = dn;
    v.sv    = sv;
    v.idx   = idx;
    return v;
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    logic [3:0] cs;
    @(negedge clk);
    if (model_en) begin
      cs = ctrl_state[3:0];
      case (ctrl_opcode)
        32'd1:        cs = 4'd3;
        32'd2:        cs = 4'd5;
        32'd3, 32'd6: cs = 4'd0;
        32'd4:        cs = 4'd9;
        32'd5:        if (cs == 4'd9) cs = 4'd10;
        default: begin
          if (cs == 4'd10)     cs = 4'd7;
          else if (cs == 4'd7) cs = 4'd8;
          else if (cs == 4'd8) cs = 4'd9;
        end
      endcase
      ctrl_state = {28'd0, cs};
      if (snap_valid) begin
        snap_ack = (ack_wait >= ack_delay);
        ack_wait++;
      end else begin
        snap_ack = 1'b0;
        ack_wait = 0;
      end
    end
    @(posedge clk);
    #1;
    if (ctrl_opcode != prev_op) begin
      if (ctrl_opcode == 32'd5) cnt5++;
      if (ctrl_opcode == 32'd6) cnt6++;
    end
    if (snap_valid && !prev_sv) snaps.push_back(snap_idx);
    if (done) cnt_done++;
    prev_op = ctrl_opcode;
    prev_sv = snap_valid;
  endtask

  task automatic clear_mon();
    cnt5 = 0;
    cnt6 = 0;
    cnt_done = 0;
    snaps.delete();
    prev_op = ctrl_opcode;
    prev_sv = snap_valid;
  endtask

  task automatic do_reset();
    model_en   = 1'b0;
    reset      = 1'b0;
    start      = 1'b0;
    mode       = 1'b0;
    tick_count = '0;
    ctrl_state = '0;
    snap_ack   = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    clear_mon();
  endtask

  // Start a scan run against the reactive model and wait (bounded) for done or err.
  task automatic run_scan(logic [CntW-1:0] tc, int delay, int budget);
    int n;
    mode       = 1'b1;
    tick_count = tc;
    ack_delay  = delay;
    model_en   = 1'b1;
    clear_mon();
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (!done && !err && n < budget) begin
      tick();
      n++;
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    int bad;

    // Reset state, applied with busy-looking inputs.
    reset = 1'b0;
    start = 1'b1;
    mode = 1'b1;
    tick_count = 16'd5;
    ctrl_state = 32'd9;
    snap_ack = 1'b1;
    tick();
    tick();
    check("reset_opcode", 64'(ctrl_opcode), 64'd0);
    check("reset_flags", 64'({busy, done, err, snap_valid}), 64'd0);
    check("reset_idx", 64'(snap_idx), 64'd0);
    check("reset_err_state", 64'(err_state), 64'd0);
    do_reset();

    // Scan test with tick_count=1, one cycle per row; start in TEST/NEXT and ack in TEST ignored.
    vecs[0]  = mkv(1'b1, 4'd0,  1'b0, 32'd1, 1'b1, 1'b0, 1'b0, 16'd0);
    vecs[1]  = mkv(1'b0, 4'd0,  1'b0, 32'd1, 1'b1, 1'b0, 1'b0, 16'd0);
    vecs[2]  = mkv(1'b0, 4'd3,  1'b0, 32'd4, 1'b1, 1'b0, 1'b0, 16'd0);
    vecs[3]  = mkv(1'b1, 4'd3,  1'b0, 32'd4, 1'b1, 1'b0, 1'b0, 16'd0);
    vecs[4]  = mkv(1'b0, 4'd9,  1'b1, 32'd0, 1'b1, 1'b0, 1'b1, 16'd0);
    vecs[5]  = mkv(1'b0, 4'd9,  1'b0, 32'd0, 1'b1, 1'b0, 1'b1, 16'd0);
    vecs[6]  = mkv(1'b0, 4'd9,  1'b1, 32'd5, 1'b1, 1'b0, 1'b0, 16'd0);
    vecs[7]  = mkv(1'b1, 4'd9,  1'b0, 32'd5, 1'b1, 1'b0, 1'b0, 16'd0);
    vecs[8]  = mkv(1'b0, 4'd10, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 16'd1);
    vecs[9]  = mkv(1'b0, 4'd7,  1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 16'd1);
    vecs[10] = mkv(1'b0, 4'd9,  1'b0, 32'd0, 1'b1, 1'b0, 1'b1, 16'd1);
    vecs[11] = mkv(1'b0, 4'd9,  1'b1, 32'd6, 1'b1, 1'b0, 1'b0, 16'd1);
    vecs[12] = mkv(1'b0, 4'd8,  1'b0, 32'd6, 1'b1, 1'b0, 1'b0, 16'd1);
    vecs[13] = mkv(1'b0, 4'd0,  1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 16'd1);
    vecs[14] = mkv(1'b0, 4'd0,  1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 16'd1);
    for (int i = 0; i < 15; i++) begin
      start      = vecs[i].start;
      mode       = vecs[i].mode;
      tick_count = vecs[i].tc;
      ctrl_state = {28'd0, vecs[i].cs};
      snap_ack   = vecs[i].ack;
      tick();
      check($sformatf("vec%0d", i), 64'({ctrl_opcode, busy, done, snap_valid, snap_idx}),
            64'({vecs[i].op, vecs[i].busy, vecs[i].done, vecs[i].sv, vecs[i].idx}));
    end
    check("vec_no_err", 64'(err), 64'd0);

    // Functional run: cs=3 at cycle 9, cs=5 at 20, cs=0 at 25; start at 12 ignored, at 26 restarts.
    do_reset();
    bad = 0;
    for (int k = 0; k < 28; k++) begin
      logic [31:0] eop;
      start = (k == 0) || (k == 12) || (k == 26);
      mode  = (k == 12);
      tick_count = 16'd3;
      ctrl_state = (k < 9) ? 32'd0 : (k < 20) ? 32'd3 : (k < 25) ? 32'd5 : 32'd0;
      tick();
      eop = (k < 9) ? 32'd1 : (k < 20) ? 32'd2 : (k < 25) ? 32'd3 : (k == 25) ? 32'd0 : 32'd1;
      if ({ctrl_opcode, busy, done, snap_valid} !== {eop, (k != 25), (k == 25), 1'b0}) begin
        bad++;
        $display("FAIL func_cycle%0d: op=%0d busy=%b done=%b sv=%b expected op=%0d busy=%b done=%b sv=0",
                 k, ctrl_opcode, busy, done, snap_valid, eop, (k != 25), (k == 25));
      end
    end
    check("func_bad_cycles", 64'(bad), 64'd0);

    // Scan test tick_count=2 against the reactive model.
    do_reset();
    run_scan(16'd2, 1, 400);
    check("scan2_done", 64'(cnt_done), 64'd1);
    check("scan2_next_count", 64'(cnt5), 64'd2);
    check("scan2_endt_count", 64'(cnt6), 64'd1);
    check("scan2_snap_count", 64'(snaps.size()), 64'd3);
    if (snaps.size() == 3) begin
      for (int i = 0; i < 3; i++) check($sformatf("scan2_snap_idx%0d", i), 64'(snaps[i]), 64'(i));
    end
    check("scan2_err", 64'(err), 64'd0);

    // tick_count=0: one snapshot then ENDT, never NEXT.
    do_reset();
    run_scan(16'd0, 2, 200);
    check("tc0_done", 64'(cnt_done), 64'd1);
    check("tc0_next_count", 64'(cnt5), 64'd0);
    check("tc0_endt_count", 64'(cnt6), 64'd1);
    check("tc0_snap_count", 64'(snaps.size()), 64'd1);
    if (snaps.size() == 1) check("tc0_snap_idx", 64'(snaps[0]), 64'd0);

    // Slow host: 10000 cycles in S_SNAP without ack is not an error.
    do_reset();
    mode = 1'b1;
    tick_count = 16'd1;
    ack_delay = 1_000_000;
    model_en = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (!snap_valid && n < 50) begin
      tick();
      n++;
    end
    check("slow_reach_snap", 64'(snap_valid), 64'd1);
    bad = 0;
    for (int i = 0; i < 10000; i++) begin
      tick();
      if (!snap_valid || ctrl_opcode != 32'd0 || err) bad++;
    end
    check("slow_hold_bad_cycles", 64'(bad), 64'd0);
    ack_delay = 0;
    tick();
    check("slow_next_after_ack", 64'({ctrl_opcode, snap_valid}), 64'({32'd5, 1'b0}));

    // Hang in S_TEST: error exactly Timeout cycles after entry.
    do_reset();
    mode = 1'b1;
    tick_count = 16'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    ctrl_state = 32'd3;
    tick();
    check("hang_in_test", 64'(ctrl_opcode), 64'd4);
    ctrl_state = 32'd8;
    n = 0;
    while (!err && n < int'(Timeout) + 10) begin
      tick();
      n++;
    end
    check("hang_cycles", 64'(n), 64'(Timeout));
    check("hang_err_state", 64'(err_state), 64'd4);
    check("hang_outputs", 64'({ctrl_opcode, busy, err}), 64'({32'd0, 1'b0, 1'b1}));
    start = 1'b1;
    ctrl_state = 32'd0;
    tick();
    start = 1'b0;
    check("hang_restart", 64'({ctrl_opcode, busy, err}), 64'({32'd1, 1'b1, 1'b0}));

    // Reset while issuing the second NEXT.
    do_reset();
    run_scan(16'd3, 0, 0);
    n = 0;
    while (!(ctrl_opcode == 32'd5 && snap_idx == 16'd1) && n < 100) begin
      tick();
      n++;
    end
    check("midreset_reach_next", 64'({ctrl_opcode, snap_idx}), 64'({32'd5, 16'd1}));
    model_en = 1'b0;
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check("midreset_outputs", 64'({ctrl_opcode, busy, snap_valid, snap_idx}),
          64'({32'd0, 1'b0, 1'b0, 16'd0}));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/prewrapper_seq.md
Name: prewrapper_seq

Overview:
- Sequences the prewrapper control unit by driving its 32-bit opcode register and watching the 4-bit state field in its status word.
- Host software issues one start with a mode and tick count. The block then runs a full functional-run or scan-test transaction.
- It stops at each scan-read point until the host consumes that snapshot.
- A per-state watchdog turns a hung handshake into a sticky error.

Parameters:
TIMEOUT, 4096, max cycles spent in any waiting state before error
CNT_W, 16, width of tick_count and snap_idx

Ports:
clk  in  1  system clock
reset  in  1  synchronous active-low reset
start  in  1  one-cycle request; sampled only in S_IDLE/S_DONE/S_ERR
mode  in  1  0 = functional run, 1 = scan test; latched on start
tick_count  in  CNT_W  number of NEXT steps in test mode; latched on start
ctrl_state  in  32  controller status word; bits [3:0] = controller state
ctrl_opcode  out  32  opcode to controller (0 NONE,1 INPUT,2 RUN,3 ENDR,4 TEST,5 NEXT,6 ENDT)
snap_valid  out  1  high while controller sits in SCAN_RD awaiting host readout
snap_ack  in  1  host has read the dft output registers for this snapshot
snap_idx  out  CNT_W  index of current snapshot, 0-based
busy  out  1  high from accepted start until done/error
done  out  1  one-cycle pulse on successful completion
err  out  1  sticky watchdog error; cleared by next accepted start
err_state  out  4  sequencer state code in which timeout occurred

Behaviour:
- Controller state codes: IDLE=0, INPUT_RDY=3, OUTPUT_VAL=5, SCAN_RD=9; cs = ctrl_state[3:0].
- All outputs are registered. Reset (reset==0 at posedge) gives: state S_IDLE, ctrl_opcode=0, snap_valid=0, snap_idx=0, busy=0, done=0, err=0, err_state=0, watchdog=0.
- Reset mid-operation aborts immediately. The controller is not drained.
- States and transitions (opcode is the value held while in the state):
  - S_IDLE, op NONE: start -> S_INPUT; latch mode and tick_count; busy=1; err=0; snap_idx=0.
  - S_INPUT, op INPUT: when cs==3 -> S_RUN if mode=0, else S_TEST.
  - S_RUN, op RUN: when cs==5 -> S_ENDR.
  - S_ENDR, op ENDR: when cs==0 -> S_DONE.
  - S_TEST, op TEST: when cs==9 -> S_SNAP.
  - S_SNAP, op NONE, snap_valid=1: when snap_ack -> S_ENDT if snap_idx==tick_count_latched, else S_NEXT. snap_valid drops the same edge.
  - S_NEXT, op NEXT: when cs!=9 -> S_WAITRD with op NONE and snap_idx+1. NEXT must be deasserted before the controller can return to SCAN_RD, so it never double-steps.
  - S_WAITRD, op NONE: when cs==9 -> S_SNAP.
  - S_ENDT, op ENDT: when cs==0 -> S_DONE.
  - S_DONE, op NONE: done=1 for this one cycle, busy=0. Next cycle goes to S_IDLE, or to S_INPUT if start is asserted.
  - S_ERR, op NONE: err=1, busy=0. start -> S_INPUT and clears err.
- Opcode changes take effect on the edge the state changes; a transition cycle never emits the old and new opcode together.
- Watchdog:
  - Clears on every state change; increments otherwise in all busy states except S_SNAP.
  - S_SNAP waits on the host and is not timed.
  - Reaching TIMEOUT -> S_ERR, with err_state = state code at timeout.
- start while busy is ignored. snap_ack outside S_SNAP is ignored.
- tick_count=0 means one snapshot (idx 0), then ENDT. tick_count=max means 2^CNT_W snapshots. The snap_idx compare is exact-width, with no wrap before the compare.
- Mode 0 never asserts snap_valid.

Test Plan:
- Functional run: start, mode=0; model controller reaches cs=3 after 9 cycles, cs=5 after 20, then 0 -> opcode sequence 1,2,3,0; done pulses once; busy high throughout; snap_valid never high.
- Scan test, tick_count=2: model cycles cs 9->10->7->8->9 per NEXT -> exactly 3 snap_valid windows (idx 0,1,2), opcode 5 issued twice, opcode 6 once, done pulse.
- Slow host: hold snap_ack low 10000 cycles in S_SNAP -> no error, opcode stays 0, snap_valid held; ack -> NEXT issued next cycle.
- Hang: controller stuck at cs=8 in S_TEST with TIMEOUT=4096 -> err=1 exactly 4096 cycles after entry, err_state=S_TEST code, opcode 0; new start clears err.
- Reset mid-test: drive reset=0 during S_NEXT -> next cycle opcode 0, busy 0, snap_idx 0; start pulse during busy is ignored, and one arriving in the S_DONE cycle starts a new run.
- tick_count=0, mode=1 -> one snapshot, then opcode 6 directly after ack, with no opcode 5 seen.
